// File: rtl/ram_b_writer.sv
`default_nettype none
//============================================================================
// Module   : ram_b_writer
// Purpose  : Streams one mix layer's bias block into the bias RAM. The layer
//            select picks a base address. Accepted words are written at
//            consecutive addresses, and a running checksum is kept.
// Revision : 1.0  initial release
//============================================================================
module ram_b_writer #(
   parameter int                 DATA_W    = 16,
   parameter int                 ADDR_W    = 8,
   parameter int                 HID_DIM   = 24,
   parameter int                 STATE_W   = 3,
   parameter logic [STATE_W-1:0] MIX1_CODE = STATE_W'(1),
   parameter logic [STATE_W-1:0] MIX2_CODE = STATE_W'(2),
   parameter logic [STATE_W-1:0] MIX3_CODE = STATE_W'(3)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [STATE_W-1:0] state,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               we,
   output logic [ADDR_W-1:0]  waddr,
   output logic [DATA_W-1:0]  wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [DATA_W-1:0]  checksum
);

   localparam int               CNT_W  = $clog2(HID_DIM + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(HID_DIM - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOAD = 1'b1
   } fsm_t;

   fsm_t               r_fsm;
   fsm_t               w_fsm_next;
   logic               w_hs;
   logic               w_accept;
   logic               w_bad_start;
   logic               w_code_ok;
   logic [ADDR_W-1:0]  w_base_sel;

   logic [ADDR_W-1:0]  r_base;
   logic [CNT_W-1:0]   r_count;
   logic [DATA_W-1:0]  r_checksum;
   logic               r_we;
   logic [ADDR_W-1:0]  r_waddr;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_done;
   logic               r_err;

   // Decode the layer select into a base address; unknown codes are flagged.
   always_comb begin
      w_code_ok  = 1'b1;
      w_base_sel = '0;
      if (state == MIX1_CODE) begin
         w_base_sel = '0;
      end else if (state == MIX2_CODE) begin
         w_base_sel = ADDR_W'(HID_DIM);
      end else if (state == MIX3_CODE) begin
         w_base_sel = ADDR_W'(2 * HID_DIM);
      end else begin
         w_code_ok  = 1'b0;
      end
   end

   // Next-state logic: abort wins over start in IDLE and over a handshake in LOAD.
   always_comb begin
      w_fsm_next  = r_fsm;
      w_hs        = 1'b0;
      w_accept    = 1'b0;
      w_bad_start = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            if (start && !abort) begin
               if (w_code_ok) begin
                  w_accept   = 1'b1;
                  w_fsm_next = S_LOAD;
               end else begin
                  w_bad_start = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (abort) begin
               w_fsm_next = S_IDLE;
            end else if (in_valid) begin
               w_hs = 1'b1;
               if (r_count == C_LAST) begin
                  w_fsm_next = S_IDLE;
               end
            end
         end
         default: w_fsm_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fsm <= S_IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   // Datapath: latch the base at start, and register each write one cycle after its handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_base     <= '0;
         r_count    <= '0;
         r_checksum <= '0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_we   <= w_hs;
         r_done <= w_hs && (r_count == C_LAST);
         r_err  <= w_bad_start;
         if (w_accept) begin
            r_base     <= w_base_sel;
            r_count    <= '0;
            r_checksum <= '0;
         end
         if (w_hs) begin
            r_waddr    <= r_base + ADDR_W'(r_count);
            r_wdata    <= in_data;
            r_count    <= r_count + CNT_W'(1);
            r_checksum <= r_checksum + in_data;
         end
      end
   end

   // in_ready depends only on the state register, so it never depends on in_valid.
   assign in_ready = (r_fsm == S_LOAD);
   assign busy     = (r_fsm == S_LOAD);
   assign we       = r_we;
   assign waddr    = r_waddr;
   assign wdata    = r_wdata;
   assign done     = r_done;
   assign err      = r_err;
   assign checksum = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_ram_b_writer.sv
`default_nettype none
//============================================================================
// Module   : tb_ram_b_writer
// Purpose  : Randomised scoreboard bench for ram_b_writer. A transaction-level
//            model predicts each bias write. A monitor compares every write the
//            design presents against the predicted write.
// Revision : 1.0  initial release
//============================================================================
module tb_ram_b_writer;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 8;
   localparam int HID_DIM = 24;
   localparam int STATE_W = 3;
   localparam int MASK    = (1 << DATA_W) - 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               abort;
   logic [STATE_W-1:0] st;
   logic               in_valid;
   logic [DATA_W-1:0]  in_data;
   logic               in_ready;
   logic               we;
   logic [ADDR_W-1:0]  waddr;
   logic [DATA_W-1:0]  wdata;
   logic               busy;
   logic               done;
   logic               err;
   logic [DATA_W-1:0]  checksum;

   ram_b_writer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .HID_DIM(HID_DIM), .STATE_W(STATE_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .state(st),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
      .err(err), .checksum(checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
      bit last;
      int sum;
   } wr_t;

   wr_t sb[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  mon_en = 1'b0;

   // Transaction-level model of one layer load.
   bit  m_load = 1'b0;
   int  m_base = 0;
   int  m_idx  = 0;
   int  m_sum  = 0;
   bit  exp_err = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Predict design behaviour from the inputs seen at each rising edge.
   always @(posedge clk) begin
      exp_err = 1'b0;
      if (!rst_n) begin
         m_load = 1'b0;
         m_idx  = 0;
         m_sum  = 0;
         sb.delete();
      end else if (!m_load) begin
         if (start && !abort) begin
            if (int'(st) >= 1 && int'(st) <= 3) begin
               m_load = 1'b1;
               m_base = (int'(st) - 1) * HID_DIM;
               m_idx  = 0;
               m_sum  = 0;
            end else begin
               exp_err = 1'b1;
            end
         end
      end else begin
         if (abort) begin
            m_load = 1'b0;
         end else if (in_valid) begin
            wr_t e;
            m_sum  = (m_sum + int'(in_data)) & MASK;
            e.addr = m_base + m_idx;
            e.data = int'(in_data);
            m_idx++;
            e.last = (m_idx == HID_DIM);
            e.sum  = m_sum;
            sb.push_back(e);
            if (m_idx == HID_DIM) m_load = 1'b0;
         end
      end
   end

   // Monitor: sample on the falling edge and check against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", int'(busy), int'(m_load));
         chk("in_ready", int'(in_ready), int'(m_load));
         if (err || exp_err) chk("err", int'(err), int'(exp_err));
         if (done && !we) chk("done_without_we", 1, 0);
         if (we) begin
            if (sb.size() == 0) begin
               chk("unexpected_we", 1, 0);
            end else begin
               wr_t e;
               e = sb.pop_front();
               chk("waddr", int'(waddr), e.addr);
               chk("wdata", int'(wdata), e.data);
               chk("done", int'(done), int'(e.last));
               chk("checksum", int'(checksum), e.sum);
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_we"}, int'(we), 0);
      chk({tag, "_waddr"}, int'(waddr), 0);
      chk({tag, "_wdata"}, int'(wdata), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_checksum"}, int'(checksum), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_in_ready"}, int'(in_ready), 0);
   endtask

   // pct < 0 toggles in_valid 1,0,1,0; abort_at/rst_at < 0 disable those events.
   task automatic run_load(input int code, input int pct, input int abort_at,
                           input int rst_at, input bit seq, input bit immediate);
      int guard;
      int cyc;
      if (!immediate) @(negedge clk);
      start    = 1'b1;
      st       = STATE_W'(code);
      in_valid = 1'b0;
      abort    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      cyc   = 0;
      while (m_load && guard < 2000) begin
         abort = (abort_at >= 0 && m_idx == abort_at);
         if (rst_at >= 0 && m_idx == rst_at) rst_n = 1'b0;
         if (pct < 0) in_valid = (cyc % 2 == 0);
         else         in_valid = ($urandom_range(0, 99) < pct);
         in_data = seq ? DATA_W'(m_idx + 1) : DATA_W'($urandom);
         start   = ($urandom_range(0, 7) == 0);
         st      = STATE_W'($urandom);
         @(negedge clk);
         guard++;
         cyc++;
      end
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      if (!rst_n) begin
         rst_n = 1'b1;
         check_zero("after_reset");
      end
      if (guard >= 2000) chk("load_timeout", 1, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      st       = '0;
      in_valid = 1'b0;
      in_data  = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      check_zero("reset");
      mon_en = 1'b1;

      // MIX2, every cycle valid, data 1..24.
      run_load(2, 100, -1, -1, 1'b1, 1'b0);
      chk("mix2_checksum_300", int'(checksum), 300);

      // MIX1 with a toggling valid.
      run_load(1, -1, -1, -1, 1'b0, 1'b0);

      // Invalid layer codes.
      for (int c = 4; c < 8; c++) run_load(c, 100, -1, -1, 1'b0, 1'b0);
      run_load(0, 100, -1, -1, 1'b0, 1'b0);

      // MIX3 aborted after ten handshakes, then a fresh MIX1 load.
      run_load(3, 100, 10, -1, 1'b0, 1'b0);
      run_load(1, 70, -1, -1, 1'b0, 1'b0);

      // Abort together with start in IDLE must do nothing.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      st    = STATE_W'(1);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);

      // Reset in the middle of a MIX2 load.
      run_load(2, 100, -1, 5, 1'b0, 1'b0);

      // Back-to-back loads, start driven in the done cycle.
      run_load(3, 100, -1, -1, 1'b0, 1'b0);
      run_load(1, 100, -1, -1, 1'b1, 1'b1);
      chk("b2b_checksum_300", int'(checksum), 300);

      // Randomised loads.
      for (int i = 0; i < 12; i++) begin
         run_load($urandom_range(0, 7), $urandom_range(30, 100),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, HID_DIM - 1) : -1,
                  -1, 1'b0, $urandom_range(0, 1) == 1);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/ram_b_writer.md
RAM_B_WRITER -- requirements
Module: ram_b_writer

Interface
REQ-001 Parameter DATA_W, default 16 (`N_LEN`), width of one bias word.
REQ-002 Parameter ADDR_W, default 8, width of the bias RAM write address.
REQ-003 Parameter HID_DIM, default 24 (`HID_DIM`), number of bias words per mix layer; 3*HID_DIM SHALL be <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 start  input  1  request to load one layer's bias block; sampled only in IDLE.
REQ-007 abort  input  1  cancel an in-progress load.
REQ-008 state  input  `STATE_LEN`  layer select: `MIX1`, `MIX2` or `MIX3`.
REQ-009 in_valid  input  1  upstream bias word valid.
REQ-010 in_data  input  DATA_W  upstream bias word.
REQ-011 in_ready  output  1  block accepts a word this cycle.
REQ-012 we  output  1  bias RAM write enable, registered.
REQ-013 waddr  output  ADDR_W  bias RAM write address, registered.
REQ-014 wdata  output  DATA_W  bias RAM write data, registered.
REQ-015 busy  output  1  high while in LOAD.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 err  output  1  one-cycle pulse when start arrives with an invalid state code.
REQ-018 checksum  output  DATA_W  sum of the accepted words of the last load, mod 2**DATA_W.

Function
REQ-019 FSM states: IDLE and LOAD; a handshake is in_valid & in_ready in the same cycle.
REQ-020 In IDLE, start with state = `MIX1`/`MIX2`/`MIX3` latches base = 0/1/2 * HID_DIM, clears word count and checksum, and enters LOAD on the next edge.
REQ-021 In IDLE, start with any other state code pulses err for exactly one cycle; the FSM stays in IDLE and base, count and checksum are unchanged.
REQ-022 in_ready is 1 in LOAD and 0 in IDLE; it is driven from the state register, with no combinational path from in_valid.
REQ-023 Each handshake at edge t drives we=1, waddr=base+count and wdata=in_data during cycle t+1, increments count and adds in_data to checksum.
REQ-024 we is 0 in every cycle not following a handshake; waddr and wdata hold their last values when we is 0.
REQ-025 Gaps in in_valid stall the load indefinitely with no timeout; words are written in strictly increasing address order with no skips.
REQ-026 The handshake that makes count reach HID_DIM moves the FSM to IDLE; done pulses in the same cycle as that last we (cycle t+1) and checksum is final in that cycle.
REQ-027 done and err SHALL never be high in the same cycle.
REQ-028 start asserted while in LOAD is ignored.
REQ-029 abort in LOAD returns the FSM to IDLE on the next edge without a done pulse.
  - A handshake in the same cycle as abort is discarded: no write.
  - A write from a handshake in the previous cycle still completes.
REQ-030 abort in IDLE has no effect; abort together with start in IDLE gives abort priority (no load, no err).
REQ-031 Address arithmetic is ADDR_W wide; count is wide enough for HID_DIM; waddr never exceeds base+HID_DIM-1.
REQ-032 After done, a new start may be accepted in the very next cycle.

Reset
REQ-033 With rst_n=0 at a rising edge: FSM goes to IDLE; count, base and checksum clear to 0; we, waddr, wdata, done and err clear to 0; busy and in_ready are 0.
REQ-034 rst_n=0 mid-LOAD discards all progress.
  - No done pulse is produced.
  - No further writes occur, including a write pending from the previous cycle.
REQ-035 All outputs SHALL be known (no X) from the first edge after reset.

Verification
REQ-036 Reset; start with `MIX2`; in_data=1..24 valid every cycle -> 24 writes at addresses 24..47 with data 1..24, done in the cycle of the write to addr 47, checksum=300.
REQ-037 `MIX1` load with in_valid toggling 1,0,1,0 -> exactly 24 writes at addresses 0..23 in order, one write per handshake, busy high throughout.
REQ-038 Start with an invalid state code -> err high for 1 cycle, busy stays 0, no we.
REQ-039 `MIX3`; abort after 10 handshakes -> addresses 48..57 written, no done, in_ready=0 on the next cycle; a following `MIX1` load starts at address 0.
REQ-040 rst_n low for 1 cycle after 5 handshakes of a `MIX2` load -> no further we, all outputs 0, FSM IDLE.
REQ-041 start asserted on the cycle after done -> second load accepted, checksum restarts from 0.
